// File: rtl/dispatch_queue.sv
// Dispatch queue: buffers fetched instructions in a small circular queue and
// issues the head entry (with resolved operands) to the ROB, RS, LSB and
// register-rename stage through one set of registered strobes and payload.

`ifndef OPE_WIDTH
`define OPE_WIDTH 6
`endif
`ifndef NON_DEPENDENT
`define NON_DEPENDENT 0
`endif
`ifndef EMPTY_INS
`define EMPTY_INS (`OPE_WIDTH'(0))
`define LB        (`OPE_WIDTH'(1))
`define LH        (`OPE_WIDTH'(2))
`define LW        (`OPE_WIDTH'(3))
`define LBU       (`OPE_WIDTH'(4))
`define LHU       (`OPE_WIDTH'(5))
`define SB        (`OPE_WIDTH'(6))
`define SH        (`OPE_WIDTH'(7))
`define SW        (`OPE_WIDTH'(8))
`define BEQ       (`OPE_WIDTH'(9))
`define BNE       (`OPE_WIDTH'(10))
`define BLT       (`OPE_WIDTH'(11))
`define BGE       (`OPE_WIDTH'(12))
`define BLTU      (`OPE_WIDTH'(13))
`define BGEU      (`OPE_WIDTH'(14))
`define ADD       (`OPE_WIDTH'(15))
`define ADDI      (`OPE_WIDTH'(16))
`define JAL       (`OPE_WIDTH'(17))
`endif

module dispatch_queue #(
    parameter int DEPTH  = 4,
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   if_valid,
    input  logic [31:0]            if_ins,
    input  logic [DATA_W-1:0]      if_pc,
    input  logic [DATA_W-1:0]      if_pred_pc,
    input  logic                   if_pred_jump,
    output logic                   if_ready,
    output logic [31:0]            dec_code,
    output logic [DATA_W-1:0]      dec_pc,
    input  logic [`OPE_WIDTH-1:0]  dec_type,
    input  logic [5:0]             dec_rd,
    input  logic [5:0]             dec_rs1,
    input  logic [5:0]             dec_rs2,
    input  logic [DATA_W-1:0]      dec_imm,
    output logic [5:0]             reg_rs1,
    output logic [5:0]             reg_rs2,
    input  logic [DATA_W-1:0]      reg_Vj,
    input  logic [DATA_W-1:0]      reg_Vk,
    input  logic [ROB_W-1:0]       reg_Qj,
    input  logic [ROB_W-1:0]       reg_Qk,
    output logic [ROB_W-1:0]       rob_Qj,
    output logic [ROB_W-1:0]       rob_Qk,
    input  logic [DATA_W-1:0]      rob_Vj,
    input  logic [DATA_W-1:0]      rob_Vk,
    input  logic                   rob_Qj_ready,
    input  logic                   rob_Qk_ready,
    input  logic                   cdb_rs_en,
    input  logic [ROB_W-1:0]       cdb_rs_id,
    input  logic [DATA_W-1:0]      cdb_rs_val,
    input  logic                   cdb_lsb_en,
    input  logic [ROB_W-1:0]       cdb_lsb_id,
    input  logic [DATA_W-1:0]      cdb_lsb_val,
    input  logic                   rob_full,
    input  logic                   rs_full,
    input  logic                   lsb_full,
    input  logic [ROB_W-1:0]       rob_tail_id,
    input  logic                   mispredict,
    output logic                   to_rob_en,
    output logic                   to_rs_en,
    output logic                   to_lsb_en,
    output logic                   to_reg_en,
    output logic [DATA_W-1:0]      issue_Vj,
    output logic [DATA_W-1:0]      issue_Vk,
    output logic [ROB_W-1:0]       issue_Qj,
    output logic [ROB_W-1:0]       issue_Qk,
    output logic [`OPE_WIDTH-1:0]  issue_type,
    output logic [DATA_W-1:0]      issue_imm,
    output logic [DATA_W-1:0]      issue_pc,
    output logic [DATA_W-1:0]      issue_pred_pc,
    output logic                   issue_pred_jump,
    output logic [5:0]             issue_rd,
    output logic [31:0]            issue_code,
    output logic [ROB_W-1:0]       issue_rob_id
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ROB_W-1:0] NO_DEP = ROB_W'(`NON_DEPENDENT);

    logic [31:0]       ins_mem     [DEPTH];
    logic [DATA_W-1:0] pc_mem      [DEPTH];
    logic [DATA_W-1:0] pred_pc_mem [DEPTH];
    logic              pred_j_mem  [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic is_empty_ins, is_mem, is_store, is_branch, dest_ok;
    logic do_enq, do_deq, do_issue;
    logic rs_hit_j, rs_hit_k, lsb_hit_j, lsb_hit_k;
    logic [DATA_W-1:0] op_Vj, op_Vk;
    logic [ROB_W-1:0]  op_Qj, op_Qk;

    assign dec_code = ins_mem[head];
    assign dec_pc   = pc_mem[head];
    assign reg_rs1  = dec_rs1;
    assign reg_rs2  = dec_rs2;
    assign rob_Qj   = reg_Qj;
    assign rob_Qk   = reg_Qk;

    assign is_empty_ins = (dec_type == `EMPTY_INS);
    assign is_mem       = (dec_type >= `LB)  && (dec_type <= `SW);
    assign is_store     = (dec_type >= `SB)  && (dec_type <= `SW);
    assign is_branch    = (dec_type >= `BEQ) && (dec_type <= `BGEU);
    assign dest_ok      = is_mem ? !lsb_full : !rs_full;

    assign if_ready = (count < CNT_W'(DEPTH)) && !mispredict;
    assign do_enq   = if_valid && if_ready && rdy;
    assign do_deq   = (count != '0) && rdy && !mispredict &&
                      (is_empty_ins || (!rob_full && dest_ok));
    assign do_issue = do_deq && !is_empty_ins;

    assign rs_hit_j  = cdb_rs_en  && (cdb_rs_id  == reg_Qj);
    assign rs_hit_k  = cdb_rs_en  && (cdb_rs_id  == reg_Qk);
    assign lsb_hit_j = cdb_lsb_en && (cdb_lsb_id == reg_Qj);
    assign lsb_hit_k = cdb_lsb_en && (cdb_lsb_id == reg_Qk);

    // Resolve source operands: register value, then same-cycle CDB bypass
    // (LSB bus wins over RS bus), then a value already finished in the ROB.
    always_comb begin
        op_Qj = reg_Qj;
        op_Qk = reg_Qk;
        if (reg_Qj == NO_DEP || rob_Qj_ready || rs_hit_j || lsb_hit_j) op_Qj = NO_DEP;
        if (reg_Qk == NO_DEP || rob_Qk_ready || rs_hit_k || lsb_hit_k) op_Qk = NO_DEP;

        if (reg_Qj == NO_DEP)  op_Vj = reg_Vj;
        else if (lsb_hit_j)    op_Vj = cdb_lsb_val;
        else if (rs_hit_j)     op_Vj = cdb_rs_val;
        else if (rob_Qj_ready) op_Vj = rob_Vj;
        else                   op_Vj = '0;

        if (reg_Qk == NO_DEP)  op_Vk = reg_Vk;
        else if (lsb_hit_k)    op_Vk = cdb_lsb_val;
        else if (rs_hit_k)     op_Vk = cdb_rs_val;
        else if (rob_Qk_ready) op_Vk = rob_Vk;
        else                   op_Vk = '0;
    end

    // Queue storage is written at the tail slot whenever an entry is accepted.
    always_ff @(posedge clk) begin
        if (rst && do_enq) begin
            ins_mem[tail]     <= if_ins;
            pc_mem[tail]      <= if_pc;
            pred_pc_mem[tail] <= if_pred_pc;
            pred_j_mem[tail]  <= if_pred_jump;
        end
    end

    // Pointer/count bookkeeping plus the registered issue strobes and payload.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            to_rob_en       <= 1'b0;
            to_rs_en        <= 1'b0;
            to_lsb_en       <= 1'b0;
            to_reg_en       <= 1'b0;
            issue_Vj        <= '0;
            issue_Vk        <= '0;
            issue_Qj        <= '0;
            issue_Qk        <= '0;
            issue_type      <= '0;
            issue_imm       <= '0;
            issue_pc        <= '0;
            issue_pred_pc   <= '0;
            issue_pred_jump <= 1'b0;
            issue_rd        <= '0;
            issue_code      <= '0;
            issue_rob_id    <= '0;
        end else if (rdy) begin
            if (mispredict) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                to_rob_en <= 1'b0;
                to_rs_en  <= 1'b0;
                to_lsb_en <= 1'b0;
                to_reg_en <= 1'b0;
            end else begin
                if (do_enq) tail <= tail + PTR_W'(1);
                if (do_deq) head <= head + PTR_W'(1);
                if (do_enq && !do_deq)      count <= count + CNT_W'(1);
                else if (!do_enq && do_deq) count <= count - CNT_W'(1);

                to_rob_en <= do_issue;
                to_lsb_en <= do_issue && is_mem;
                to_rs_en  <= do_issue && !is_mem;
                to_reg_en <= do_issue && !is_store && !is_branch;

                if (do_issue) begin
                    issue_Vj        <= op_Vj;
                    issue_Vk        <= op_Vk;
                    issue_Qj        <= op_Qj;
                    issue_Qk        <= op_Qk;
                    issue_type      <= dec_type;
                    issue_imm       <= dec_imm;
                    issue_pc        <= pc_mem[head];
                    issue_pred_pc   <= pred_pc_mem[head];
                    issue_pred_jump <= pred_j_mem[head];
                    issue_rd        <= dec_rd;
                    issue_code      <= ins_mem[head];
                    issue_rob_id    <= rob_tail_id;
                end
            end
        end
    end

endmodule

// File: doc/dispatch_queue.md
DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, instruction-queue entries (power of two, >= 2).
REQ-002 SHALL provide parameter ROB_W, default 4, ROB id width; id 0 = `NON_DEPENDENT.
REQ-003 SHALL provide parameter DATA_W, default 32, operand/immediate/pc width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 rdy  in  1  global ready; low freezes all state and outputs.
REQ-007 if_valid  in  1  fetcher offers {if_ins, if_pc, if_pred_pc, if_pred_jump} this cycle.
REQ-008 if_ins / if_pc / if_pred_pc / if_pred_jump  in  32/DATA_W/DATA_W/1  fetched payload.
REQ-009 if_ready  out  1  queue accepts an entry this cycle.
REQ-010 dec_code / dec_pc  out  32/DATA_W  head entry to decoder (combinational).
REQ-011 dec_type / dec_rd / dec_rs1 / dec_rs2 / dec_imm  in  `OPE_WIDTH/6/6/6/DATA_W  decoded head.
REQ-012 reg_rs1 / reg_rs2  out  6  register-file lookup; reg_Vj / reg_Vk / reg_Qj / reg_Qk  in  DATA_W/ROB_W.
REQ-013 rob_Qj / rob_Qk  out  ROB_W  ROB lookup; rob_Vj / rob_Vk / rob_Qj_ready / rob_Qk_ready  in.
REQ-014 cdb_rs_en / cdb_rs_id / cdb_rs_val, cdb_lsb_en / cdb_lsb_id / cdb_lsb_val  in  1/ROB_W/DATA_W  broadcast buses.
REQ-015 rob_full / rs_full / lsb_full  in  1  destination cannot accept next cycle; rob_tail_id  in  ROB_W  id for next allocation.
REQ-016 mispredict  in  1  flush request from ROB.
REQ-017 to_rob_en / to_rs_en / to_lsb_en / to_reg_en  out  1  registered one-cycle issue strobes.
REQ-018 issue_Vj / issue_Vk / issue_Qj / issue_Qk / issue_type / issue_imm / issue_pc / issue_pred_pc / issue_pred_jump / issue_rd / issue_code / issue_rob_id  out  registered payload shared by ROB, RS, LSB, reg rename.

Function
REQ-019 Queue SHALL be a circular buffer, head/tail pointers log2(DEPTH) bits wrapping modulo DEPTH, count 0..DEPTH.
REQ-020 if_ready SHALL equal (count < DEPTH) && !mispredict; enqueue occurs when if_valid && if_ready && rdy.
REQ-021 Head SHALL issue (dequeue) when count > 0 && rdy && !mispredict && !rob_full && (load/store ? !lsb_full : !rs_full).
REQ-022 Simultaneous enqueue and dequeue SHALL leave count unchanged; at count == DEPTH enqueue is refused even if dequeue occurs.
REQ-023 Head with dec_type == `EMPTY_INS SHALL dequeue with all strobes low, ignoring full flags.
REQ-024 Operand Qj SHALL be reg_Qj unless reg_Qj == 0, rob_Qj_ready, or a CDB matches; else 0; Qk identically.
REQ-025 Vj priority: reg_Qj == 0 -> reg_Vj; cdb_lsb match -> cdb_lsb_val; cdb_rs match -> cdb_rs_val; rob_Qj_ready -> rob_Vj; else 0; Vk identically.
REQ-026 Issue cycle N SHALL drive strobes high in cycle N+1 only: to_rob_en=1; to_lsb_en for LB/LH/LW/LBU/LHU/SB/SH/SW, else to_rs_en; to_reg_en unless store or branch.
REQ-027 issue_rob_id SHALL capture rob_tail_id in the issue cycle; throughput SHALL be one instruction per cycle.
REQ-028 A CDB broadcast in the cycle after issue is not this block's concern; RS/LSB snoop it.
REQ-029 mispredict SHALL, next edge, empty queue (head=tail, count=0), clear all strobes, discard any same-cycle enqueue/issue.
REQ-030 With rdy low, pointers, count, strobes and payload SHALL hold.

Reset
REQ-031 While rst==0 at a clock edge: count=0, head=tail=0, all strobes 0, payload 0; if_ready=1 the first cycle after release.
REQ-032 Reset asserted mid-issue SHALL cancel the pending strobe; no partial dispatch.

Verification
REQ-033 Fill: DEPTH=4, full flags high, 5 if_valid pulses -> 4 accepted, if_ready=0 on 5th, count=4.
REQ-034 Streaming: 8 ALU instrs, no full -> to_rs_en high 8 consecutive cycles, issue_rob_id follows rob_tail_id.
REQ-035 Bypass: reg_Qj=3, cdb_rs_en=1 id 3 val 0x55 same cycle -> issue_Qj=0, issue_Vj=0x55; lsb and rs both match id 3 -> lsb value wins.
REQ-036 Routing: LW with lsb_full=1 stalls, rs_full ignored; SW issues to_lsb_en=1, to_reg_en=0; BEQ to_rs_en=1, to_reg_en=0.
REQ-037 Flush: count=3, mispredict with if_valid -> next cycle count=0, strobes 0, enqueued entry lost.
REQ-038 Wrap/rdy: 10 enq/deq cycles at DEPTH=4 with rdy low on cycle 5 -> order preserved, no duplicate or lost issue.
